// File: rtl/led_pattern_fsm.sv
// rtl/led_pattern_fsm.sv - parametrised N-channel LED pattern sequencer with run/pause and speed select
module led_pattern_fsm #(
  parameter int N_LED       = 8,
  parameter int TICK_CYCLES = 12500000,
  localparam int STEP_W     = $clog2(2 * N_LED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [2:0]        mode,
  input  logic [1:0]        speed,
  input  logic [N_LED-1:0]  user_pat,
  output logic [N_LED-1:0]  led,
  output logic [STEP_W-1:0] step,
  output logic              tick,
  output logic              wrap
);

  localparam int CNT_W = $clog2(TICK_CYCLES);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2:0]         mode_q, mode_q_nxt;
  logic [N_LED-1:0]   led_nxt;
  logic [STEP_W-1:0]  step_nxt, step_adv;
  logic               tick_nxt, wrap_nxt;
  logic               mode_change, terminal, last_step;

  // LED image for a given mode and step index; chase reads the live user pattern
  function automatic logic [N_LED-1:0] pattern(input logic [2:0] m,
                                               input logic [STEP_W-1:0] s,
                                               input logic [N_LED-1:0] up);
    logic [N_LED-1:0] p;
    int si;
    int k;
    si = int'(s);
    p  = '0;
    k  = 0;
    case (m)
      3'd0: for (int i = 0; i < N_LED; i++) p[i] = ((i % 2) == 0) ^ (si != 0);
      3'd1: begin
        k = (si < N_LED) ? si + 1 : 2 * N_LED - 1 - si;
        for (int i = 0; i < N_LED; i++) p[i] = (i < k);
      end
      3'd2: begin
        k = (si < N_LED) ? si : 2 * N_LED - 2 - si;
        for (int i = 0; i < N_LED; i++) p[i] = (i == k);
      end
      3'd3: begin
        case (si)
          0: begin
            p[0]       = 1'b1;
            p[N_LED-1] = 1'b1;
          end
          1: p = '1;
          2: begin
            p          = '1;
            p[0]       = 1'b0;
            p[N_LED-1] = 1'b0;
          end
          default: p = '0;
        endcase
      end
      3'd4: begin
        for (int i = 0; i < N_LED; i++) begin
          k    = (i + si) % N_LED;
          p[k] = up[i];
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // number of steps in one cycle of each pattern; reserved modes have a single step
  function automatic int pat_len(input logic [2:0] m);
    case (m)
      3'd0:    return 2;
      3'd1:    return 2 * N_LED;
      3'd2:    return 2 * N_LED - 2;
      3'd3:    return 4;
      3'd4:    return N_LED;
      default: return 1;
    endcase
  endfunction

  assign mode_change = (mode != mode_q);
  // ">=" keeps a mid-count speed increase from running past the shorter period
  assign terminal    = int'(cnt) >= ((TICK_CYCLES >> speed) - 1);
  assign last_step   = int'(step) >= (pat_len(mode_q) - 1);
  assign step_adv    = last_step ? '0 : step + 1'b1;

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_LOAD;
      cnt    <= '0;
      mode_q <= '0;
      led    <= '0;
      step   <= '0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_q_nxt;
      led    <= led_nxt;
      step   <= step_nxt;
      tick   <= tick_nxt;
      wrap   <= wrap_nxt;
    end
  end

  // next state: a mode change always restarts through LOAD
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  state_nxt = run ? S_RUN : S_PAUSE;
      S_RUN: begin
        if (mode_change)  state_nxt = S_LOAD;
        else if (!run)    state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (mode_change)  state_nxt = S_LOAD;
        else if (run)     state_nxt = S_RUN;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // datapath: load restarts the pattern, run counts and advances, pause holds
  always_comb begin
    cnt_nxt    = cnt;
    mode_q_nxt = mode_q;
    led_nxt    = led;
    step_nxt   = step;
    tick_nxt   = 1'b0;
    wrap_nxt   = 1'b0;
    case (state)
      S_LOAD: begin
        mode_q_nxt = mode;
        cnt_nxt    = '0;
        step_nxt   = '0;
        led_nxt    = pattern(mode, '0, user_pat);
      end
      S_RUN: begin
        if (!mode_change && run) begin
          if (terminal) begin
            cnt_nxt  = '0;
            step_nxt = step_adv;
            led_nxt  = pattern(mode_q, step_adv, user_pat);
            tick_nxt = 1'b1;
            wrap_nxt = last_step;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_fsm.sv
// tb/tb_led_pattern_fsm.sv - self-checking bench for led_pattern_fsm with N_LED=4, TICK_CYCLES=8
module tb_led_pattern_fsm;

  localparam int N = 4;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [1:0] speed = 2'd0;
  logic [3:0] user_pat = 4'd0;
  logic [3:0] led;
  logic [2:0] step;
  logic       tick;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  // reference model: pending-restart flag, pause flag, elapsed cycles in step
  bit         m_load;
  bit         m_paused;
  int         m_cnt;
  int         m_step;
  int         m_mq;
  logic [3:0] m_led;
  logic       m_tick;
  logic       m_wrap;

  logic [3:0] tl[$];
  logic       tw[$];
  int         tg[$];

  led_pattern_fsm #(.N_LED(N), .TICK_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .run(run), .mode(mode), .speed(speed),
    .user_pat(user_pat), .led(led), .step(step), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pat(int m, int s, logic [3:0] up);
    logic [7:0] d;
    int k;
    case (m)
      0: return (s == 0) ? 4'b0101 : 4'b1010;
      1: begin
        k = (s < N) ? s + 1 : 2 * N - 1 - s;
        return 4'((1 << k) - 1);
      end
      2: begin
        k = (s < N) ? s : 2 * N - 2 - s;
        return 4'(1 << k);
      end
      3: case (s)
        0: return 4'b1001;
        1: return 4'b1111;
        2: return 4'b0110;
        default: return 4'b0000;
      endcase
      4: begin
        d = {up, up} << s;
        return d[7:4];
      end
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int plen(int m);
    case (m)
      0: return 2;
      1: return 2 * N;
      2: return 2 * N - 2;
      3: return 4;
      4: return N;
      default: return 1;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_load = 1'b1; m_paused = 1'b0; m_cnt = 0; m_step = 0; m_mq = 0;
    m_led = 4'd0; m_tick = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_load) begin
      m_mq = int'(mode); m_step = 0; m_cnt = 0;
      m_led = pat(int'(mode), 0, user_pat);
      m_tick = 1'b0; m_wrap = 1'b0;
      m_load = 1'b0; m_paused = !run;
    end else begin
      m_tick = 1'b0; m_wrap = 1'b0;
      if (int'(mode) != m_mq) m_load = 1'b1;
      else if (m_paused) m_paused = !run;
      else if (!run) m_paused = 1'b1;
      else if (m_cnt + 1 >= (T >> speed)) begin
        m_cnt  = 0;
        m_wrap = (m_step == plen(m_mq) - 1);
        m_step = (m_step + 1) % plen(m_mq);
        m_led  = pat(m_mq, m_step, user_pat);
        m_tick = 1'b1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("led", 32'(led), 32'(m_led));
    chk("step", 32'(step), m_step);
    chk("tick", 32'(tick), 32'(m_tick));
    chk("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic collect(int want);
    int gap;
    int budget;
    tl.delete(); tw.delete(); tg.delete();
    gap = 0;
    budget = want * (T + 2) + 20;
    while (tl.size() < want && budget > 0) begin
      cyc();
      gap++;
      budget--;
      if (tick === 1'b1) begin
        tl.push_back(led); tw.push_back(wrap); tg.push_back(gap);
        gap = 0;
      end
    end
    chk("collect_count", tl.size(), want);
  endtask

  task automatic wait_tick(string tag, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < 40);
    chk(tag, 32'(tick), 32'd1);
  endtask

  initial begin
    logic [3:0] e1[8] = '{4'd3, 4'd7, 4'd15, 4'd7, 4'd3, 4'd1, 4'd0, 4'd1};
    logic [3:0] e2[6] = '{4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1};
    logic [3:0] e3[4] = '{4'd15, 4'd6, 4'd0, 4'd9};
    logic [3:0] e4[3] = '{4'd6, 4'd12, 4'd9};
    logic [3:0] save_led;
    logic [2:0] save_step;
    int n;

    model_reset();
    // reset state
    rst = 1'b1; run = 1'b1; mode = 3'd1; speed = 2'd0;
    cyc(); cyc();
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_step", 32'(step), 32'd0);

    // FILL sequence, 8-cycle spacing, wrap on 0000->0001
    rst = 1'b0;
    cyc();
    chk("t1_load_led", 32'(led), 32'd1);
    collect(8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_led", 32'(tl[i]), 32'(e1[i]));
      chk("t1_wrap", 32'(tw[i]), (i == 7) ? 32'd1 : 32'd0);
      chk("t1_gap", tg[i], T);
    end

    // BOUNCE then FRAME
    mode = 3'd2;
    cyc(); cyc();
    chk("t2_load_led", 32'(led), 32'd1);
    collect(6);
    for (int i = 0; i < 6; i++) chk("t2_bounce", 32'(tl[i]), 32'(e2[i]));
    chk("t2_wrap", 32'(tw[5]), 32'd1);
    mode = 3'd3;
    cyc(); cyc();
    chk("t2_frame_load", 32'(led), 32'd9);
    collect(4);
    for (int i = 0; i < 4; i++) chk("t2_frame", 32'(tl[i]), 32'(e3[i]));

    // CHASE and live user pattern change mid-step
    mode = 3'd4; user_pat = 4'b0011;
    cyc(); cyc();
    chk("t3_load_led", 32'(led), 32'd3);
    collect(3);
    for (int i = 0; i < 3; i++) chk("t3_chase", 32'(tl[i]), 32'(e4[i]));
    cyc(); cyc(); cyc();
    user_pat = 4'b0001;
    save_led = led;
    n = 0;
    do begin
      cyc();
      n++;
      if (tick !== 1'b1) chk("t3_hold", 32'(led), 32'(save_led));
    end while (tick !== 1'b1 && n < 20);
    chk("t3_new_led", 32'(led), 32'd1);
    collect(1);
    chk("t3_rot", 32'(tl[0]), 32'd2);

    // mode change on the terminal cycle: no tick, reload, full period after LOAD
    mode = 3'd2;
    cyc(); cyc();
    wait_tick("t4_sync", n);
    for (int i = 0; i < 7; i++) cyc();
    mode = 3'd0;
    cyc();
    chk("t4_no_tick", 32'(tick), 32'd0);
    cyc();
    chk("t4_led", 32'(led), 32'd5);
    chk("t4_step", 32'(step), 32'd0);
    wait_tick("t4_tick", n);
    chk("t4_period", n, T);

    // speed jump at cnt=5, then pause for 20 cycles
    for (int i = 0; i < 5; i++) cyc();
    speed = 2'd3;
    cyc();
    chk("t5_fast_tick", 32'(tick), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t5_every_cycle", 32'(tick), 32'd1);
    end
    run = 1'b0;
    cyc();
    chk("t5_stop_tick", 32'(tick), 32'd0);
    save_led = led; save_step = step;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t5_pause_tick", 32'(tick), 32'd0);
      chk("t5_pause_led", 32'(led), 32'(save_led));
      chk("t5_pause_step", 32'(step), 32'(save_step));
    end
    run = 1'b1;
    cyc(); cyc();
    chk("t5_resume", 32'(tick), 32'd1);

    // reserved mode: dark, single step, wrap on every tick
    mode = 3'd5;
    cyc(); cyc();
    chk("rsv_led", 32'(led), 32'd0);
    cyc();
    chk("rsv_tick", 32'(tick), 32'd1);
    chk("rsv_wrap", 32'(wrap), 32'd1);
    chk("rsv_step", 32'(step), 32'd0);

    // asynchronous reset mid-pattern
    mode = 3'd1; speed = 2'd0;
    for (int i = 0; i < 13; i++) cyc();
    #2 rst = 1'b1;
    #1;
    chk("t6_async_led", 32'(led), 32'd0);
    chk("t6_async_step", 32'(step), 32'd0);
    model_reset();
    cyc(); cyc();
    mode = 3'd3;
    rst = 1'b0;
    cyc();
    chk("t6_release_led", 32'(led), 32'd9);

    // randomized traffic against the model
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      if ($urandom_range(0, 39) == 0) mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) user_pat = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
